// File: rtl/fft_bitrev_reorder.sv
// Collects one bit-reversed FFT frame per bank of a ping-pong buffer and replays
// bins 0..N_OUT_BINS-1 in natural order over a valid/ready output.
module fft_bitrev_reorder #(
    parameter int WIDTH         = 13,
    parameter int N_FFT         = 256,
    parameter int N_OUT_BINS    = N_FFT / 2 + 1,
    parameter int BIN_IDX_WIDTH = $clog2(N_FFT)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     spi_en_inf_system_sync,
    input  logic                     valid_in,
    input  logic [WIDTH-1:0]         Re_in,
    input  logic [WIDTH-1:0]         Im_in,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_Re,
    output logic [WIDTH-1:0]         out_Im,
    output logic [BIN_IDX_WIDTH-1:0] out_bin_idx,
    output logic                     out_last,
    output logic                     overflow
);

    localparam int DW = 2 * WIDTH;
    localparam logic [BIN_IDX_WIDTH-1:0] LAST_CNT = BIN_IDX_WIDTH'(N_FFT - 1);
    localparam logic [BIN_IDX_WIDTH-1:0] LAST_BIN = BIN_IDX_WIDTH'(N_OUT_BINS - 1);

    typedef enum logic {
        S_IDLE,
        S_STREAM
    } rdState_t;

    function automatic logic [BIN_IDX_WIDTH-1:0] bitRev(input logic [BIN_IDX_WIDTH-1:0] v);
        logic [BIN_IDX_WIDTH-1:0] r;
        for (int i = 0; i < BIN_IDX_WIDTH; i++) begin
            r[i] = v[BIN_IDX_WIDTH-1-i];
        end
        return r;
    endfunction

    logic [DW-1:0]            r_mem0 [N_OUT_BINS];
    logic [DW-1:0]            r_mem1 [N_OUT_BINS];

    logic [BIN_IDX_WIDTH-1:0] r_wrCnt;
    logic                     r_wrBank;
    logic                     r_rdBank;
    logic [1:0]               r_bankFull;
    logic                     r_drop;
    logic                     r_overflow;

    rdState_t                 r_state;
    rdState_t                 w_nextState;
    logic [BIN_IDX_WIDTH-1:0] r_rdIdx;
    logic                     r_issDone;
    logic                     r_s1Valid;
    logic [BIN_IDX_WIDTH-1:0] r_s1Idx;
    logic [DW-1:0]            r_s1Data;

    logic                     r_outValid;
    logic [WIDTH-1:0]         r_outRe;
    logic [WIDTH-1:0]         r_outIm;
    logic [BIN_IDX_WIDTH-1:0] r_outIdx;
    logic                     r_outLast;

    logic [BIN_IDX_WIDTH-1:0] w_wrAddr;
    logic                     w_frameStart;
    logic                     w_dropNow;
    logic                     w_wrEn;
    logic                     w_frameEnd;
    logic [1:0]               w_setMask;
    logic [1:0]               w_clrMask;
    logic                     w_issue;
    logic [BIN_IDX_WIDTH-1:0] w_rdAddr;
    logic                     w_move;
    logic                     w_lastAcc;

    // The drop decision for a frame is made on its first sample, so that sample
    // must already see the fresh decision rather than the previous frame's flag.
    assign w_wrAddr     = bitRev(r_wrCnt);
    assign w_frameStart = valid_in && (r_wrCnt == '0);
    assign w_dropNow    = w_frameStart ? r_bankFull[r_wrBank] : r_drop;
    assign w_wrEn       = valid_in && !w_dropNow &&
                          ({{(32-BIN_IDX_WIDTH){1'b0}}, w_wrAddr} < 32'(N_OUT_BINS));
    assign w_frameEnd   = valid_in && (r_wrCnt == LAST_CNT) && !w_dropNow;
    assign w_setMask    = w_frameEnd ? (r_wrBank ? 2'b10 : 2'b01) : 2'b00;
    assign w_clrMask    = w_lastAcc  ? (r_rdBank ? 2'b10 : 2'b01) : 2'b00;

    // The read-stage register acts as a skid slot so a stall never loses a read in flight.
    assign w_move       = r_s1Valid && (!r_outValid || out_ready);

    always_ff @(posedge clk) begin
        if (w_wrEn) begin
            if (r_wrBank) begin
                r_mem1[w_wrAddr] <= {Re_in, Im_in};
            end else begin
                r_mem0[w_wrAddr] <= {Re_in, Im_in};
            end
        end
        if (w_issue) begin
            r_s1Data <= r_rdBank ? r_mem1[w_rdAddr] : r_mem0[w_rdAddr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrCnt    <= '0;
            r_wrBank   <= 1'b0;
            r_rdBank   <= 1'b0;
            r_bankFull <= 2'b00;
            r_drop     <= 1'b0;
            r_overflow <= 1'b0;
        end else if (!spi_en_inf_system_sync) begin
            r_wrCnt    <= '0;
            r_wrBank   <= 1'b0;
            r_rdBank   <= 1'b0;
            r_bankFull <= 2'b00;
            r_drop     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (valid_in) begin
                r_wrCnt <= r_wrCnt + 1'b1;
            end
            if (w_frameStart) begin
                r_drop <= r_bankFull[r_wrBank];
                if (r_bankFull[r_wrBank]) begin
                    r_overflow <= 1'b1;
                end
            end
            if (w_frameEnd) begin
                r_wrBank <= ~r_wrBank;
            end
            if (w_lastAcc) begin
                r_rdBank <= ~r_rdBank;
            end
            r_bankFull <= (r_bankFull | w_setMask) & ~w_clrMask;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else if (!spi_en_inf_system_sync) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Bin 0 is issued in the same cycle IDLE spots a full bank, which keeps the
    // first output two edges after the frame completes.
    always_comb begin
        w_nextState = r_state;
        w_issue     = 1'b0;
        w_rdAddr    = r_rdIdx;
        w_lastAcc   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_bankFull[r_rdBank]) begin
                    w_issue     = 1'b1;
                    w_rdAddr    = '0;
                    w_nextState = S_STREAM;
                end
            end
            S_STREAM: begin
                w_issue = !r_issDone && (!r_s1Valid || w_move);
                if (r_outValid && out_ready && r_outLast) begin
                    w_lastAcc   = 1'b1;
                    w_nextState = S_IDLE;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdIdx    <= '0;
            r_issDone  <= 1'b0;
            r_s1Valid  <= 1'b0;
            r_s1Idx    <= '0;
            r_outValid <= 1'b0;
            r_outRe    <= '0;
            r_outIm    <= '0;
            r_outIdx   <= '0;
            r_outLast  <= 1'b0;
        end else if (!spi_en_inf_system_sync) begin
            r_rdIdx    <= '0;
            r_issDone  <= 1'b0;
            r_s1Valid  <= 1'b0;
            r_s1Idx    <= '0;
            r_outValid <= 1'b0;
            r_outRe    <= '0;
            r_outIm    <= '0;
            r_outIdx   <= '0;
            r_outLast  <= 1'b0;
        end else begin
            if (w_issue) begin
                r_s1Idx <= w_rdAddr;
                if (w_rdAddr == LAST_BIN) begin
                    r_issDone <= 1'b1;
                end else begin
                    r_issDone <= 1'b0;
                    r_rdIdx   <= w_rdAddr + 1'b1;
                end
            end
            if (w_issue) begin
                r_s1Valid <= 1'b1;
            end else if (w_move) begin
                r_s1Valid <= 1'b0;
            end
            if (w_move) begin
                r_outValid <= 1'b1;
                r_outRe    <= r_s1Data[DW-1:WIDTH];
                r_outIm    <= r_s1Data[WIDTH-1:0];
                r_outIdx   <= r_s1Idx;
                r_outLast  <= (r_s1Idx == LAST_BIN);
            end else if (r_outValid && out_ready) begin
                r_outValid <= 1'b0;
                r_outLast  <= 1'b0;
            end
        end
    end

    assign out_valid   = r_outValid;
    assign out_Re      = r_outRe;
    assign out_Im      = r_outIm;
    assign out_bin_idx = r_outIdx;
    assign out_last    = r_outLast;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Bench for fft_bitrev_reorder: frames are built in natural order, sent bit-reversed,
// and the replayed bins are matched against a queue of expected bins.
module tb_fft_bitrev_reorder;

    localparam int WIDTH = 13;
    localparam int N_FFT = 256;
    localparam int NB    = N_FFT / 2 + 1;
    localparam int IW    = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             spi_en;
    logic             valid_in;
    logic [WIDTH-1:0] Re_in;
    logic [WIDTH-1:0] Im_in;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_Re;
    logic [WIDTH-1:0] out_Im;
    logic [IW-1:0]    out_bin_idx;
    logic             out_last;
    logic             overflow;

    fft_bitrev_reorder #(
        .WIDTH(WIDTH),
        .N_FFT(N_FFT),
        .N_OUT_BINS(NB),
        .BIN_IDX_WIDTH(IW)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .spi_en_inf_system_sync(spi_en),
        .valid_in(valid_in),
        .Re_in(Re_in),
        .Im_in(Im_in),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_Re(out_Re),
        .out_Im(out_Im),
        .out_bin_idx(out_bin_idx),
        .out_last(out_last),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] re;
        logic [WIDTH-1:0] im;
        int               idx;
        bit               last;
    } bin_t;

    bin_t             expQ[$];
    logic [WIDTH-1:0] frameRe[N_FFT];
    logic [WIDTH-1:0] frameIm[N_FFT];
    int               cmpCnt = 0;
    int               failCnt = 0;
    int               stored = 0;
    int               cyc = 0;
    int               lastEdge = 0;
    int               lastRise = -1;
    int               lastAccCyc = -1;
    bit               monEn = 0;
    bit               randReady = 0;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmpCnt++;
        assert (obs === exp) else begin
            failCnt++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int bitRev(input int v);
        int r = 0;
        for (int i = 0; i < IW; i++) begin
            r = (r << 1) | (v & 1);
            v = v >> 1;
        end
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
        if (randReady) out_ready = 1'($urandom_range(0, 1));
    endtask

    // mode 0: ramp frame (Re=n, Im=-n in natural order); mode 1: random frame
    task automatic applyStimulus(input int mode, input int nSamples);
        bit drop;
        bin_t b;
        for (int n = 0; n < N_FFT; n++) begin
            frameRe[n] = (mode == 0) ? WIDTH'(n)  : WIDTH'($urandom);
            frameIm[n] = (mode == 0) ? WIDTH'(-n) : WIDTH'($urandom);
        end
        drop = (stored == 2);
        for (int k = 0; k < nSamples; k++) begin
            valid_in = 1'b1;
            Re_in    = frameRe[bitRev(k)];
            Im_in    = frameIm[bitRev(k)];
            tick();
        end
        valid_in = 1'b0;
        lastEdge = cyc;
        if (!drop && nSamples == N_FFT) begin
            for (int n = 0; n < NB; n++) begin
                b.re   = frameRe[n];
                b.im   = frameIm[n];
                b.idx  = n;
                b.last = (n == NB - 1);
                expQ.push_back(b);
            end
            stored++;
        end
    endtask

    task automatic waitDrain(input string tag, input int budget);
        int n = 0;
        while (expQ.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        checkOutput(tag, expQ.size(), 0);
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Output monitor: checks handshake stability and pops expected bins on acceptance
    initial begin
        bin_t             e;
        logic             prevValid = 1'b0;
        logic             prevReady = 1'b0;
        logic [WIDTH-1:0] prevRe = '0;
        logic [WIDTH-1:0] prevIm = '0;
        logic [IW-1:0]    prevIdx = '0;
        logic             prevLast = 1'b0;
        forever begin
            @(negedge clk);
            if (monEn && rst_n) begin
                if (prevValid && !prevReady) begin
                    checkOutput("hold_valid", out_valid, 1'b1);
                    checkOutput("hold_re", out_Re, prevRe);
                    checkOutput("hold_im", out_Im, prevIm);
                    checkOutput("hold_idx", out_bin_idx, prevIdx);
                    checkOutput("hold_last", out_last, prevLast);
                end
                if (out_valid && !prevValid) lastRise = cyc;
                if (out_valid && out_ready) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected_out", out_valid, 1'b0);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("bin_re", out_Re, e.re);
                        checkOutput("bin_im", out_Im, e.im);
                        checkOutput("bin_idx", out_bin_idx, e.idx);
                        checkOutput("bin_last", out_last, e.last);
                        if (e.last) begin
                            stored--;
                            lastAccCyc = cyc;
                        end
                    end
                end
                prevValid = out_valid;
                prevReady = out_ready;
                prevRe    = out_Re;
                prevIm    = out_Im;
                prevIdx   = out_bin_idx;
                prevLast  = out_last;
            end else begin
                prevValid = 1'b0;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int s1Edge;
        rst_n     = 1'b0;
        spi_en    = 1'b1;
        valid_in  = 1'b0;
        Re_in     = '0;
        Im_in     = '0;
        out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_valid", out_valid, 1'b0);
        checkOutput("rst_last", out_last, 1'b0);
        checkOutput("rst_overflow", overflow, 1'b0);
        checkOutput("rst_idx", out_bin_idx, 0);
        checkOutput("rst_re", out_Re, 0);
        checkOutput("rst_im", out_Im, 0);
        rst_n = 1'b1;
        monEn = 1;
        tick();

        $display("[TB] ramp frame, out_ready high");
        out_ready = 1'b1;
        applyStimulus(0, N_FFT);
        s1Edge = lastEdge;
        waitDrain("s1_drain", 400);
        checkOutput("s1_first_latency", lastRise - s1Edge, 2);
        checkOutput("s1_last_cycle", lastAccCyc - s1Edge, 130);
        checkOutput("s1_overflow", overflow, 1'b0);

        $display("[TB] ramp frame, random out_ready");
        randReady = 1;
        applyStimulus(0, N_FFT);
        waitDrain("s2_drain", 1500);
        randReady = 0;
        out_ready = 1'b1;

        $display("[TB] three back-to-back random frames");
        applyStimulus(1, N_FFT);
        applyStimulus(1, N_FFT);
        applyStimulus(1, N_FFT);
        waitDrain("s3_drain", 600);
        checkOutput("s3_overflow", overflow, 1'b0);

        $display("[TB] three frames with out_ready low");
        out_ready = 1'b0;
        applyStimulus(1, N_FFT);
        applyStimulus(1, N_FFT);
        applyStimulus(1, N_FFT);
        repeat (5) tick();
        checkOutput("s4_overflow", overflow, 1'b1);
        checkOutput("s4_stalled_valid", out_valid, 1'b1);
        out_ready = 1'b1;
        waitDrain("s4_drain", 600);
        repeat (10) tick();
        checkOutput("s4_idle_valid", out_valid, 1'b0);

        $display("[TB] sync clear mid-frame");
        applyStimulus(1, 100);
        spi_en = 1'b0;
        tick();
        checkOutput("s5_clr_overflow", overflow, 1'b0);
        checkOutput("s5_clr_valid", out_valid, 1'b0);
        spi_en = 1'b1;
        repeat (5) tick();
        checkOutput("s5_quiet_valid", out_valid, 1'b0);
        applyStimulus(1, N_FFT);
        waitDrain("s5_drain", 400);

        $display("[TB] async reset mid-replay");
        applyStimulus(1, N_FFT);
        repeat (40) tick();
        checkOutput("s6_valid_before", out_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        monEn = 0;
        #1;
        checkOutput("s6_rst_valid", out_valid, 1'b0);
        checkOutput("s6_rst_last", out_last, 1'b0);
        checkOutput("s6_rst_overflow", overflow, 1'b0);
        expQ.delete();
        stored = 0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        monEn = 1;
        tick();
        applyStimulus(1, N_FFT);
        waitDrain("s6_drain", 400);
        repeat (5) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmpCnt, failCnt);
        $finish;
    end

endmodule

// File: doc/fft_bitrev_reorder.md
Name: fft_bitrev_reorder

Overview:
Sink for the last R2-SDF FFT stage. It captures the bit-reversed complex output stream of one N_FFT frame into a ping-pong buffer and replays the non-redundant bins 0..N_OUT_BINS-1 in natural order. Replay uses a valid/ready handshake toward the power-spectrum/filterbank stage. The FFT side has no backpressure; a frame that finds no free bank is dropped and flagged.

Parameters:
WIDTH, 13, width of Re/Im on input and output (two's complement)
N_FFT, 256, frame length (power of 2)
N_OUT_BINS, N_FFT/2+1, bins replayed per frame (2..N_FFT)
BIN_IDX_WIDTH, $clog2(N_FFT), width of bin index

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
spi_en_inf_system_sync  in  1  system enable; low = synchronous clear of all state
valid_in  in  1  input sample valid (from last fft_stage valid_out)
Re_in  in  WIDTH  real part, bit-reversed order
Im_in  in  WIDTH  imaginary part
out_valid  out  1  output bin valid
out_ready  in  1  downstream accepts
out_Re  out  WIDTH  real part, natural order
out_Im  out  WIDTH  imaginary part
out_bin_idx  out  BIN_IDX_WIDTH  bin number of current output
out_last  out  1  high with bin N_OUT_BINS-1
overflow  out  1  sticky: a frame was dropped

Behaviour:
- Reset (rst_n low, async) and spi_en_inf_system_sync low (sync, same priority) clear: out_valid, out_Re, out_Im, out_bin_idx, out_last, overflow, wr_cnt, wr_bank, rd_bank, bank_full[1:0], drop flag, read FSM to IDLE. RAM contents are not cleared. A sync clear mid-frame discards the partial frame and any replay in progress.
- Write side: wr_cnt (log2 N_FFT bits) increments on each valid_in and wraps N_FFT-1 -> 0. Write address = bit-reverse of wr_cnt. Write only if the address is < N_OUT_BINS and the frame is not dropped.
- Frame start (valid_in with wr_cnt==0): if bank_full[wr_bank]==1, set drop for this frame and set overflow. Otherwise clear drop.
- Frame end (valid_in with wr_cnt==N_FFT-1, not dropped): set bank_full[wr_bank] and toggle wr_bank. Dropped frames set no flags and do not toggle.
- Buffer: two banks of N_OUT_BINS x 2*WIDTH. Synchronous read with 1-cycle latency. Simultaneous write to one bank and read of the other bank is supported.
- Read FSM:
  - IDLE: if bank_full[rd_bank] -> STREAM, rd_idx=0.
  - STREAM: issue a read whenever the output register is empty or being consumed this cycle (out_valid & out_ready). rd_idx increments per issued read and stops after N_OUT_BINS-1. The output register loads RAM data one cycle after issue, with out_bin_idx = the issued index and out_last = (index==N_OUT_BINS-1).
  - Handshake rules: out_Re/out_Im/out_bin_idx/out_last hold stable while out_valid & !out_ready. No bubbles while out_ready stays high.
  - On the accepted handshake with out_last: clear bank_full[rd_bank], toggle rd_bank, go to IDLE. If the other bank is already full, re-enter STREAM the next cycle.
- Latency: with out_ready high, the first out_valid occurs on the 2nd rising edge after the edge that sets bank_full. Bins then follow one per cycle.
- Set and clear of bank_full on the same edge target different banks by construction, and both take effect.
- overflow is cleared only by reset or sync clear.

Test Plan:
- N_FFT=256, N_OUT_BINS=129, out_ready=1: one frame where sample k has Re_in=bitrev8(k), Im_in=-bitrev8(k) -> out_Re=0..128 and out_Im=0..-128 on consecutive cycles; out_bin_idx matches out_Re; out_last only at 128; first out_valid 2 cycles after the 256th input.
- Same frame with out_ready toggled by a random 50% pattern -> identical 129-bin sequence, no duplicates or skips; outputs held stable while stalled.
- Three back-to-back frames (768 consecutive valid_in), out_ready=1 -> three complete ordered 129-bin bursts with correct data per frame; overflow stays 0.
- out_ready=0 throughout, three frames sent -> frames 1 and 2 fill both banks, frame 3 dropped, overflow=1. Raising out_ready then yields frames 1 and 2 only, then out_valid=0.
- spi_en_inf_system_sync low for 1 cycle after 100 samples of a frame -> all state cleared, no output. A following full frame is reordered correctly from wr_cnt=0.
- rst_n asserted mid-replay (asynchronous, between edges) -> out_valid, out_last, overflow go 0 immediately. After release, a new frame replays correctly.
